// File: rtl/tile_dma_pkg.sv
// Shared video package: tile-map geometry and the tile-attribute DMA state encoding.
package tile_dma_pkg;

    localparam int TILES_H    = 28;
    localparam int TILES_V    = 19;
    localparam int TATTR_SIZE = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VBL = 3'd1,
        ST_FETCH    = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } dma_state_e;

endpackage

// File: rtl/tile_dma_if.sv
// Tile DMA bus bundle: word-read channel to system memory plus the attribute-RAM write port.
interface tile_dma_if #(
    parameter int TATTR_AW = 10,
    parameter int MEM_AW   = 32
);
    logic                mem_req;
    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_ack;
    logic [31:0]         mem_rdata;
    logic [TATTR_AW-1:0] tattr_addr;
    logic [7:0]          tattr_wdata;
    logic                tattr_wenable;

    modport master (
        output mem_req, mem_addr, tattr_addr, tattr_wdata, tattr_wenable,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, tattr_addr, tattr_wdata, tattr_wenable,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/tile_dma_sync_2ff.sv
// Two-flop level synchronizer for the vertical-blank crossing.
// Only built when TILE_DMA_VSYNC_EN is defined; otherwise no such flops exist.
`ifdef TILE_DMA_VSYNC_EN
module sync_2ff (
    input  logic wclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`endif

// File: rtl/tile_dma.sv
// Tile-attribute DMA: copies a byte run from system memory into the tile-attribute RAM.
// Define TILE_DMA_VSYNC_EN to hold each launch until the next vertical-blank rising edge.
module tile_dma
    import tile_dma_pkg::*;
#(
    parameter int TATTR_AW = 10,
    parameter int MEM_AW   = 32
) (
    input  logic                wclk,
    input  logic                rst_n,
    input  logic [MEM_AW-1:0]   cfg_src,
    input  logic [TATTR_AW-1:0] cfg_dst,
    input  logic [TATTR_AW:0]   cfg_len,
    input  logic                start,
    input  logic                vblank_async,
    output logic                busy,
    output logic                done_irq,
    tile_dma_if.master          bus
);

    localparam logic [MEM_AW-1:0]   WORD_MASK = ~MEM_AW'(3);
    localparam logic [TATTR_AW:0]   LEN_MAX   = {1'b1, {TATTR_AW{1'b0}}};

    dma_state_e          state_q, state_d;
    logic [MEM_AW-1:0]   src_q;
    logic [TATTR_AW-1:0] dst_q;
    logic [TATTR_AW-1:0] wa_q;
    logic [TATTR_AW:0]   rem_q;
    logic [1:0]          bidx_q;
    logic [31:0]         word_q;
    logic                done_q;
    logic [TATTR_AW:0]   len_clamped;
    logic                last_byte;
    logic                word_end;
    logic                vbl_rise;

`ifdef TILE_DMA_VSYNC_EN
    logic vbl_s, vbl_s_q;

    sync_2ff u_vbl_sync (
        .wclk  (wclk),
        .rst_n (rst_n),
        .d     (vblank_async),
        .q     (vbl_s)
    );

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) vbl_s_q <= 1'b0;
        else        vbl_s_q <= vbl_s;
    end

    assign vbl_rise = vbl_s & ~vbl_s_q;
    localparam dma_state_e LAUNCH_ST = ST_WAIT_VBL;
`else
    logic unused_vbl;
    assign unused_vbl = vblank_async;
    assign vbl_rise   = 1'b0;
    localparam dma_state_e LAUNCH_ST = ST_FETCH;
`endif

    // Lengths beyond the RAM size would only rewrite the same entries again.
    assign len_clamped = (cfg_len[TATTR_AW] && |cfg_len[TATTR_AW-1:0]) ? LEN_MAX : cfg_len;
    assign last_byte   = (rem_q == (TATTR_AW+1)'(1));
    assign word_end    = (bidx_q == 2'd3);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = (len_clamped == '0) ? ST_DONE : LAUNCH_ST;
            ST_WAIT_VBL: if (vbl_rise) state_d = ST_FETCH;
            ST_FETCH:    if (bus.mem_ack) state_d = ST_WRITE;
            ST_WRITE: begin
                if (last_byte)     state_d = ST_DONE;
                else if (word_end) state_d = ST_FETCH;
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_q != ST_IDLE);
        bus.mem_req       = (state_q == ST_FETCH);
        bus.tattr_wenable = (state_q == ST_WRITE);
        bus.mem_addr      = src_q;
        bus.tattr_addr    = wa_q;
        bus.tattr_wdata   = word_q[7:0];
        done_irq          = done_q;
    end

    // wa_q/word_q are frozen on the final byte so the RAM port holds its last write.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            wa_q   <= '0;
            rem_q  <= '0;
            bidx_q <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q <= cfg_src & WORD_MASK;
                        dst_q <= cfg_dst;
                        rem_q <= len_clamped;
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ack) begin
                        word_q <= bus.mem_rdata;
                        wa_q   <= dst_q;
                        bidx_q <= 2'd0;
                    end
                end
                ST_WRITE: begin
                    rem_q  <= rem_q - 1'b1;
                    bidx_q <= bidx_q + 1'b1;
                    if (word_end) src_q <= src_q + MEM_AW'(4);
                    if (last_byte || word_end) begin
                        dst_q <= wa_q + 1'b1;
                    end else begin
                        wa_q   <= wa_q + 1'b1;
                        word_q <= {8'h00, word_q[31:8]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
